// File: rtl/uart_serial_transmitter_if.sv
// Byte-stream handshake between a producer and the UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_serial_transmitter_if;
    logic [7:0] transmit_data;
    logic       transmit_valid;
    logic       transmit_ready;

    modport master (output transmit_data, output transmit_valid, input transmit_ready);
    modport slave  (input transmit_data, input transmit_valid, output transmit_ready);
endinterface

// File: rtl/uart_serial_transmitter.sv
// 8N1/8N2 UART transmitter: small input FIFO feeding a start/data/stop framing FSM.
// Back-to-back queued bytes are sent with no idle gap between frames.
module uart_serial_transmitter #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    uart_serial_transmitter_if.slave   tx_if,
    output logic                       serial_tx,
    output logic                       busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(STOP_CLKS);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [1:0]       rst_sync_q;
    logic             rst_n_int;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    assign tx_if.transmit_ready = (count_q != FULL_CNT);
    assign push                 = tx_if.transmit_valid && tx_if.transmit_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_if.transmit_data;
    end

    // State register: control resets, the shift register holds data only.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // Next-state logic; STOP reloads straight into START so frames abut.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so the pin is a plain flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign serial_tx = tx_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_serial_transmitter.sv
// Bench for uart_serial_transmitter: two instances (one and two stop bits), a
// driver that logs accepted bytes into a scoreboard, and serial line monitors.
module tb_uart_serial_transmitter;

    localparam int CF    = 1600;
    localparam int BR    = 100;
    localparam int CPB   = CF / BR;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] data;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    logic tx0, tx1, busy0, busy1;

    exp_t expq0[$];
    exp_t expq1[$];
    int   starts0[$];
    int   starts1[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_serial_transmitter_if ifc0 ();
    uart_serial_transmitter_if ifc1 ();

    uart_serial_transmitter #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .tx_if(ifc0.slave), .serial_tx(tx0), .busy(busy0));

    uart_serial_transmitter #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .tx_if(ifc1.slave), .serial_tx(tx1), .busy(busy1));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic txs(input int d);
        return (d == 1) ? tx1 : tx0;
    endfunction
    function automatic logic bsy(input int d);
        return (d == 1) ? busy1 : busy0;
    endfunction
    function automatic logic rdy(input int d);
        return (d == 1) ? ifc1.transmit_ready : ifc0.transmit_ready;
    endfunction
    function automatic int qsize(input int d);
        return (d == 1) ? expq1.size() : expq0.size();
    endfunction
    function automatic exp_t qfront(input int d);
        return (d == 1) ? expq1[0] : expq0[0];
    endfunction

    // Ideal line level k cycles into a frame carrying byte b.
    function automatic logic exp_bit(input int k, input logic [7:0] b);
        int j;
        j = k / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    task automatic set_in(input int d, input logic v, input logic [7:0] b);
        if (d == 1) begin ifc1.transmit_valid = v; ifc1.transmit_data = b; end
        else        begin ifc0.transmit_valid = v; ifc0.transmit_data = b; end
    endtask

    task automatic idle_in(input int d);
        @(negedge clk);
        set_in(d, 1'b0, 8'h00);
    endtask

    // Holds valid until accepted, scrambling data while the FIFO is full.
    task automatic push(input int d, input logic [7:0] b, output int acc, output int waited);
        exp_t e;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        while (!rdy(d) && waited < 2000) begin
            set_in(d, 1'b1, 8'($urandom));
            @(negedge clk);
            waited++;
        end
        if (!rdy(d)) begin
            chk($sformatf("dut%0d ready_timeout", d), waited, 0);
            set_in(d, 1'b0, 8'h00);
        end else begin
            set_in(d, 1'b1, b);
            acc    = cyc + 1;
            e.data = b;
            e.acc  = acc;
            if (d == 1) expq1.push_back(e); else expq0.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic wait_drain(input int d, input int budget);
        int n;
        n = 0;
        while ((qsize(d) != 0 || bsy(d)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d drained_in_budget", d), (n < budget), 1);
    endtask

    // Line monitor: each frame must start exactly when the scoreboard says,
    // follow the ideal waveform every cycle, and decode to the queued byte.
    task automatic mon(input int d);
        int         sb, flen, last_end, s, wave_err, want;
        logic [7:0] dec;
        logic       b;
        exp_t       e;
        bit         aborted, have;
        sb       = (d == 1) ? 2 : 1;
        flen     = (9 + sb) * CPB;
        last_end = -100000;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_end = -100000;
                continue;
            end
            if (txs(d) !== 1'b0) continue;
            s    = cyc;
            have = (qsize(d) != 0);
            if (have) e = qfront(d);
            else begin
                chk($sformatf("dut%0d unexpected_frame", d), 0, 1);
                e.data = 8'h00;
                e.acc  = s - 1;
            end
            if (d == 1) starts1.push_back(s); else starts0.push_back(s);
            want = (e.acc + 1 > last_end + 1) ? e.acc + 1 : last_end + 1;
            chk($sformatf("dut%0d frame_start", d), s, want);
            wave_err = 0;
            dec      = 8'h00;
            aborted  = 1'b0;
            for (int k = 1; k < flen; k++) begin
                @(negedge clk);
                if (!reset_n) begin
                    aborted = 1'b1;
                    break;
                end
                b = txs(d);
                if (b !== exp_bit(k, e.data)) wave_err++;
                if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) dec[k/CPB-1] = b;
            end
            if (aborted) begin
                last_end = -100000;
                continue;
            end
            if (have) begin
                if (d == 1) void'(expq1.pop_front()); else void'(expq0.pop_front());
            end
            chk($sformatf("dut%0d frame_wave_errors", d), wave_err, 0);
            chk($sformatf("dut%0d frame_data", d), dec, e.data);
            last_end = s + flen - 1;
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, waited, acc1, acc5, acc6, s, n, lows, busys;
        int a[6];
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        chk("reset tx0", tx0, 1);
        chk("reset busy0", busy0, 0);
        chk("reset ready0", ifc0.transmit_ready, 1);
        chk("reset tx1", tx1, 1);
        chk("reset busy1", busy1, 0);
        chk("reset ready1", ifc1.transmit_ready, 1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte: latency and busy release.
        starts0.delete();
        push(0, 8'hA5, acc, waited);
        idle_in(0);
        n = 0;
        while (busy0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("A5 busy_fall_cycle", cyc, acc + 161);
        chk("A5 start_latency", (starts0.size() > 0) ? starts0[0] : -1, acc + 1);
        wait_drain(0, 400);

        // Three back-to-back frames.
        starts0.delete();
        push(0, 8'h00, acc, waited);
        push(0, 8'hFF, acc, waited);
        push(0, 8'h3C, acc, waited);
        idle_in(0);
        wait_drain(0, 1000);
        chk("b2b frames", starts0.size(), 3);
        if (starts0.size() == 3) begin
            chk("b2b gap1", starts0[1] - starts0[0], 160);
            chk("b2b gap2", starts0[2] - starts0[1], 160);
        end

        // Six bytes held valid into a depth-4 FIFO.
        starts0.delete();
        for (int i = 0; i < 6; i++) begin
            push(0, 8'(i + 1), a[i], waited);
            if (i == 5) chk("byte6 waited_while_full", (waited > 0), 1);
        end
        acc1 = a[0];
        acc5 = a[4];
        acc6 = a[5];
        idle_in(0);
        chk("fill acc5", acc5, acc1 + 4);
        wait_drain(0, 1500);
        chk("fill frames", starts0.size(), 6);
        if (starts0.size() >= 2) chk("byte6 accept_after_pop", acc6, starts0[1] + 1);

        // Reset in the middle of a frame with two bytes queued.
        starts0.delete();
        push(0, 8'h5A, acc, waited);
        push(0, 8'h11, acc, waited);
        push(0, 8'h22, acc, waited);
        idle_in(0);
        n = 0;
        while (starts0.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test frame_started", starts0.size(), 1);
        s = (starts0.size() > 0) ? starts0[0] : cyc;
        // Data bit 5 of 0x5A is low, so the line visibly snaps back high.
        while (cyc < s + 100) @(negedge clk);
        chk("pre_reset line_low", tx0, 0);
        chk("pre_reset busy", busy0, 1);
        reset_n = 1'b0;
        #1;
        chk("midreset tx0", tx0, 1);
        chk("midreset busy0", busy0, 0);
        chk("midreset ready0", ifc0.transmit_ready, 1);
        expq0.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
            if (busy0 !== 1'b0) busys++;
        end
        chk("post_reset quiet_line", lows, 0);
        chk("post_reset quiet_busy", busys, 0);
        chk("post_reset ready0", ifc0.transmit_ready, 1);

        // Two stop bits.
        starts1.delete();
        push(1, 8'h81, acc, waited);
        push(1, 8'h7E, acc, waited);
        idle_in(1);
        wait_drain(1, 1000);
        chk("sb2 frames", starts1.size(), 2);
        if (starts1.size() == 2) chk("sb2 frame_len", starts1[1] - starts1[0], 176);

        // Random stream with random gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_in(0);
                repeat ($urandom_range(1, 200)) @(negedge clk);
            end
            push(0, 8'($urandom), acc, waited);
        end
        idle_in(0);
        wait_drain(0, 5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
